// File: rtl/execute_stage_p.sv
// ---------------------------------------------------------------------------
// execute_stage_p
//   Execute pipeline stage between decode/register-read and memory. Runs one
//   ALU operation per accepted instruction and registers the result, the
//   forwarded store operand and the N/Z/C/V flags into the EX/MEM register.
//   Valid/ready handshake, downstream stall, flush, and a WIDTH-cycle
//   shift-add unsigned multiply.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears all state
//   in_valid    upstream presents an instruction
//   in_ready    stage can accept this cycle (idle and not stalled)
//   ALUControl  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT,
//               110 MUL, 111 PASSB
//   toALU1/2    operands A, B
//   storedRt1   store data travelling with the instruction
//   stall_in    downstream stall; EX/MEM register holds
//   flush       kill in-flight work (synchronous, highest priority)
//   memAddr     registered ALU result
//   storedRt2   registered store data
//   out_valid   EX/MEM register holds a valid instruction
//   negative, zero, CarryOut, overflow   registered flags
//   busy        multiply in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new instruction (non-MUL ops complete here)
// MUL   | shift-add iterations, one multiplier bit per cycle
// DONE  | product ready, waiting for a non-stalled cycle to load EX/MEM
// ---------------------------------------------------------------------------
module execute_stage_p #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] toALU1,
  input  logic [WIDTH-1:0] toALU2,
  input  logic [WIDTH-1:0] storedRt1,
  input  logic             stall_in,
  input  logic             flush,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] storedRt2,
  output logic             out_valid,
  output logic             negative,
  output logic             zero,
  output logic             CarryOut,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     st_hold;

  logic accept;
  logic is_mul;

  assign in_ready = (state == S_IDLE) && !stall_in;
  assign busy     = (state != S_IDLE);
  // in_ready does not look at flush, so the kill must also gate acceptance.
  assign accept   = in_valid && in_ready && !flush;
  assign is_mul   = (ALUControl == OP_MUL);

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             slt_bit;

  assign add_full = {1'b0, toALU1} + {1'b0, toALU2};
  assign sub_full = {1'b0, toALU1} + {1'b0, ~toALU2} + {{WIDTH{1'b0}}, 1'b1};
  assign slt_bit  = $signed(toALU1) < $signed(toALU2);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (toALU1[WIDTH-1] == toALU2[WIDTH-1]) &&
                  (add_full[WIDTH-1] != toALU1[WIDTH-1]);
      end
      OP_SUB: begin
        // carry out of A + ~B + 1 is the "no borrow" indication
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (toALU1[WIDTH-1] != toALU2[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != toALU1[WIDTH-1]);
      end
      OP_AND:   alu_res = toALU1 & toALU2;
      OP_OR:    alu_res = toALU1 | toALU2;
      OP_XOR:   alu_res = toALU1 ^ toALU2;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_PASSB: alu_res = toALU2;
      default:  alu_res = '0;
    endcase
  end

  // ---------------- multiply result ----------------
  logic [WIDTH-1:0] mul_res;
  logic             mul_v;

  assign mul_res = acc[WIDTH-1:0];
  assign mul_v   = |acc[2*WIDTH-1:WIDTH];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      // iterations run regardless of stall_in; only the EX/MEM load waits
      S_MUL:   if (cnt == LAST_ITER) state_nxt = S_DONE;
      S_DONE:  if (!stall_in)        state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // ---------------- multiplier datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      st_hold <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && is_mul) begin
      mcand   <= {{WIDTH{1'b0}}, toALU1};
      mplier  <= toALU2;
      acc     <= '0;
      cnt     <= '0;
      st_hold <= storedRt1;
    end else if (state == S_MUL) begin
      // multiplicand walks left while multiplier bits are consumed LSB first
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // ---------------- EX/MEM register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memAddr   <= '0;
      storedRt2 <= '0;
      out_valid <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      CarryOut  <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      // data registers keep their contents; only the valid bit is killed
      out_valid <= 1'b0;
    end else if (!stall_in) begin
      if (state == S_DONE) begin
        memAddr   <= mul_res;
        storedRt2 <= st_hold;
        out_valid <= 1'b1;
        negative  <= mul_res[WIDTH-1];
        zero      <= (mul_res == '0);
        CarryOut  <= 1'b0;
        overflow  <= mul_v;
      end else if (accept && !is_mul) begin
        memAddr   <= alu_res;
        storedRt2 <= storedRt1;
        out_valid <= 1'b1;
        negative  <= alu_res[WIDTH-1];
        zero      <= (alu_res == '0);
        CarryOut  <= alu_c;
        overflow  <= alu_v;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_p.sv
module tb_execute_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WIDTH=32 instance
  logic        iv32, ir32, st32, fl32, ov32, n32, z32, c32, v32, busy32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, sr32, mem32, sro32;

  // WIDTH=8 instance
  logic        iv8, ir8, st8, fl8, ov8, n8, z8, c8, v8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, sr8, mem8, sro8;

  execute_stage_p #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .ALUControl(op32), .toALU1(a32), .toALU2(b32), .storedRt1(sr32),
    .stall_in(st32), .flush(fl32), .memAddr(mem32), .storedRt2(sro32),
    .out_valid(ov32), .negative(n32), .zero(z32), .CarryOut(c32),
    .overflow(v32), .busy(busy32)
  );

  execute_stage_p #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .ALUControl(op8), .toALU1(a8), .toALU2(b8), .storedRt1(sr8),
    .stall_in(st8), .flush(fl8), .memAddr(mem8), .storedRt2(sro8),
    .out_valid(ov8), .negative(n8), .zero(z8), .CarryOut(c8),
    .overflow(v8), .busy(busy8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  nzcv;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a fresh EX/MEM load is any cycle with out_valid high
  // whose preceding edge was not a stall hold.
  logic stall_e = 1'b0;
  always @(posedge clk) stall_e <= st32;

  always @(negedge clk) begin
    if (reset && ov32 && !stall_e) begin
      if (sbq.size() == 0) begin
        check("unexpected out_valid", {63'b0, ov32}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("sb memAddr", {32'b0, mem32}, {32'b0, mon_e.res});
        check("sb storedRt2", {32'b0, sro32}, {32'b0, mon_e.st});
        check("sb flags", {60'b0, n32, z32, c32, v32}, {60'b0, mon_e.nzcv});
      end
    end
  end

  task automatic push(input logic [31:0] res, input logic [31:0] st, input logic [3:0] nzcv);
    exp_t e;
    e.res = res; e.st = st; e.nzcv = nzcv;
    sbq.push_back(e);
  endtask

  task automatic run_mul32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                           input int done_stall, input bit mid_stall, input int exp_lat,
                           input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
    int  lat;
    bit  busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    op32 = 3'b110; a32 = a; b32 = b; sr32 = st; iv32 = 1'b1;
    #1;
    check("mul in_ready before accept", {63'b0, ir32}, 64'd1);
    push(exp_res, st, exp_nzcv);
    tick();
    iv32 = 1'b0;
    sr32 = 32'hDEADBEEF;
    check("mul busy after accept", {63'b0, busy32}, 64'd1);
    check("mul in_ready while busy", {63'b0, ir32}, 64'd0);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ov32) begin
        lat = k;
        break;
      end
      if (busy32 !== 1'b1) busy_ok = 1'b0;
      if (mid_stall && k == 3) st32 = 1'b1;
      if (mid_stall && k == 8) st32 = 1'b0;
      if (done_stall > 0 && k == 32) st32 = 1'b1;
      if (done_stall > 0 && k == 32 + done_stall) st32 = 1'b0;
    end
    st32 = 1'b0;
    check("mul latency", 64'(lat), 64'(exp_lat));
    check("mul busy held", {63'b0, busy_ok}, 64'd1);
    check("mul busy cleared", {63'b0, busy32}, 64'd0);
    tick();
  endtask

  vec_t tv[14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat8;
    bit seen;

    tv[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    tv[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
    tv[2]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
    tv[3]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    tv[4]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
    tv[5]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    tv[6]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000};
    tv[7]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
    tv[8]  = '{3'b100, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0100};
    tv[9]  = '{3'b111, 32'h00000123, 32'h80000001, 32'h80000001, 4'b1000};
    tv[10] = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
    tv[11] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 4'b0000};
    tv[12] = '{3'b000, 32'h12345678, 32'h11111111, 32'h23456789, 4'b0000};
    tv[13] = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111};

    reset = 1'b0;
    iv32 = 0; st32 = 0; fl32 = 0; op32 = 0; a32 = 0; b32 = 0; sr32 = 0;
    iv8  = 0; st8  = 0; fl8  = 0; op8  = 0; a8  = 0; b8  = 0; sr8  = 0;
    repeat (3) tick();
    check("reset memAddr", {32'b0, mem32}, 64'd0);
    check("reset out_valid", {63'b0, ov32}, 64'd0);
    check("reset flags", {60'b0, n32, z32, c32, v32}, 64'd0);
    check("reset busy", {63'b0, busy32}, 64'd0);
    reset = 1'b1;
    tick();

    // back-to-back ALU sweep
    for (int i = 0; i < 14; i++) begin
      op32 = tv[i].op; a32 = tv[i].a; b32 = tv[i].b; sr32 = 32'hC0DE0000 + i;
      iv32 = 1'b1;
      #1;
      check("sweep in_ready", {63'b0, ir32}, 64'd1);
      push(tv[i].res, 32'hC0DE0000 + i, tv[i].nzcv);
      tick();
      check("sweep out_valid", {63'b0, ov32}, 64'd1);
    end
    iv32 = 1'b0;
    tick();
    check("bubble out_valid", {63'b0, ov32}, 64'd0);

    // stall holds EX/MEM and blocks acceptance
    op32 = 3'b000; a32 = 32'h100; b32 = 32'h23; sr32 = 32'h51; iv32 = 1'b1;
    push(32'h123, 32'h51, 4'b0000);
    tick();
    st32 = 1'b1; a32 = 32'h2; b32 = 32'h2; sr32 = 32'h52;
    #1;
    check("stall in_ready", {63'b0, ir32}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall memAddr held", {32'b0, mem32}, 64'h123);
      check("stall out_valid held", {63'b0, ov32}, 64'd1);
      check("stall in_ready low", {63'b0, ir32}, 64'd0);
    end
    st32 = 1'b0;
    push(32'h4, 32'h52, 4'b0000);
    tick();
    iv32 = 1'b0;
    tick();

    // multiplies
    run_mul32(32'h00010000, 32'h00010000, 32'hABCD, 0, 1'b0, 33, 32'h0, 4'b0101);
    run_mul32(32'd7, 32'd6, 32'h1111, 0, 1'b0, 33, 32'd42, 4'b0000);
    run_mul32(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2222, 0, 1'b0, 33, 32'h1, 4'b0001);
    run_mul32(32'h00012345, 32'h00000100, 32'h3333, 2, 1'b0, 35, 32'h01234500, 4'b0000);
    run_mul32(32'd3, 32'hFFFFFFFF, 32'h4444, 0, 1'b1, 33, 32'hFFFFFFFD, 4'b1001);

    // flush during MUL: no result ever emerges
    op32 = 3'b110; a32 = 32'd5; b32 = 32'd5; sr32 = 32'h66; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    repeat (9) tick();
    fl32 = 1'b1;
    tick();
    fl32 = 1'b0;
    check("flush mul busy", {63'b0, busy32}, 64'd0);
    check("flush mul in_ready", {63'b0, ir32}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ov32) seen = 1'b1;
    end
    check("flush mul no out_valid", {63'b0, seen}, 64'd0);

    // flush kills a valid EX/MEM entry and blocks the same-cycle accept
    op32 = 3'b000; a32 = 32'd9; b32 = 32'd1; sr32 = 32'h77; iv32 = 1'b1;
    push(32'd10, 32'h77, 4'b0000);
    tick();
    fl32 = 1'b1; a32 = 32'd1; b32 = 32'd1;
    tick();
    check("flush out_valid", {63'b0, ov32}, 64'd0);
    check("flush data kept", {32'b0, mem32}, 64'd10);
    fl32 = 1'b0; iv32 = 1'b0;
    tick();

    // flush and stall together: flush wins
    a32 = 32'd20; b32 = 32'd22; sr32 = 32'h88; iv32 = 1'b1;
    push(32'd42, 32'h88, 4'b0000);
    tick();
    iv32 = 1'b0; st32 = 1'b1; fl32 = 1'b1;
    tick();
    check("flush+stall out_valid", {63'b0, ov32}, 64'd0);
    check("flush+stall data kept", {32'b0, mem32}, 64'd42);
    st32 = 1'b0; fl32 = 1'b0;
    tick();

    // asynchronous reset mid-multiply
    op32 = 3'b110; a32 = 32'd3; b32 = 32'd3; sr32 = 32'h99; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    repeat (5) tick();
    check("pre-reset busy", {63'b0, busy32}, 64'd1);
    reset = 1'b0;
    #2;
    check("async reset memAddr", {32'b0, mem32}, 64'd0);
    check("async reset storedRt2", {32'b0, sro32}, 64'd0);
    check("async reset busy", {63'b0, busy32}, 64'd0);
    check("async reset in_ready", {63'b0, ir32}, 64'd1);
    check("async reset flags", {60'b0, n32, z32, c32, v32}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // WIDTH=8 instance
    op8 = 3'b000; a8 = 8'hFF; b8 = 8'h01; sr8 = 8'h5A; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    check("w8 add out_valid", {63'b0, ov8}, 64'd1);
    check("w8 add memAddr", {56'b0, mem8}, 64'd0);
    check("w8 add flags", {60'b0, n8, z8, c8, v8}, 64'b0110);
    check("w8 add storedRt2", {56'b0, sro8}, 64'h5A);
    tick();
    op8 = 3'b110; a8 = 8'h10; b8 = 8'h10; sr8 = 8'hA5; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; sr8 = 8'h00;
    lat8 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ov8) begin
        lat8 = k;
        break;
      end
    end
    check("w8 mul latency", 64'(lat8), 64'd9);
    check("w8 mul memAddr", {56'b0, mem8}, 64'd0);
    check("w8 mul flags", {60'b0, n8, z8, c8, v8}, 64'b0101);
    check("w8 mul storedRt2", {56'b0, sro8}, 64'hA5);
    tick();

    check("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage_p.md
# execute_stage_p

Parametrised execute pipeline stage between decode/register-read and memory. Performs one ALU operation per accepted instruction on WIDTH-bit operands and registers the result (memory address / writeback value), the forwarded store operand and the four ALU flags into the EX/MEM pipeline register. Adds valid/ready handshaking, downstream stall, flush and a multi-cycle shift-add multiply.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (≥ 4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage accepts this cycle: in_ready = (state==IDLE) && !stall_in
- ALUControl  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 MUL, 111 PASSB
- toALU1, toALU2  input  WIDTH  operands A, B
- storedRt1  input  WIDTH  store data travelling with the instruction
- stall_in  input  1  downstream stall; EX/MEM register holds
- flush  input  1  kill in-flight work
- memAddr  output  WIDTH  registered ALU result
- storedRt2  output  WIDTH  registered store data
- out_valid  output  1  EX/MEM register holds a valid instruction
- negative, zero, CarryOut, overflow  output  1  registered flags
- busy  output  1  multiply in progress (state != IDLE)

## Operation
- Accept = in_valid && in_ready. Non-MUL accept: result, flags, storedRt1 loaded into output regs at that edge; out_valid ← 1.
- Cycle with no accept and !stall_in: out_valid ← 0 (bubble); data regs may hold.
- stall_in=1: all output regs hold, no accept.
- Arithmetic, all mod 2^WIDTH:
  - ADD: CarryOut = carry out of bit WIDTH-1; overflow = signed overflow.
  - SUB: A + ~B + 1; CarryOut = 1 when no borrow (A ≥ B unsigned); overflow = signed overflow.
  - AND/OR/XOR/PASSB: CarryOut = overflow = 0.
  - SLT: result = 1 if A < B signed else 0; CarryOut = overflow = 0.
  - MUL: unsigned; result = low WIDTH bits of product; overflow = (high WIDTH bits != 0); CarryOut = 0.
  - All ops: negative = result[WIDTH-1]; zero = (result == 0).
- FSM: IDLE, MUL, DONE.
  - IDLE → MUL on accept with ALUControl=110: latch A, B, storedRt1; clear 2·WIDTH accumulator; iteration counter ← 0.
  - MUL: one multiplier bit per cycle, independent of stall_in. After iteration WIDTH-1 → DONE.
  - DONE: if !stall_in, load product/flags/store data into output regs, out_valid ← 1, → IDLE; else wait in DONE.
- flush (synchronous, highest priority): out_valid ← 0, FSM → IDLE, counter cleared, no accept that cycle. Data regs keep value.
- flush and stall_in together: flush wins.

## Timing
- Reset (async, reset=0): memAddr=0, storedRt2=0, out_valid=0, all flags 0, state IDLE, busy=0, counter 0. Release takes effect on the next clk edge.
- Non-MUL latency: 1 cycle (accept edge → out_valid high after that edge). Throughput 1/cycle.
- MUL latency: accept at edge E0, out_valid high after edge E0+WIDTH+1 (stall-free). busy high from after E0 until after the loading edge. in_ready low throughout.
- Stall during DONE extends latency cycle-for-cycle. Stall during MUL does not pause iterations.
- Output regs never change while stall_in=1 and flush=0.

## Test plan
- Reset: drive reset=0 mid-MUL (busy=1) → outputs 0, busy=0, in_ready=1 immediately (asynchronous), with no clock edge required.
- ALU sweep, WIDTH=32: ADD 0x7FFFFFFF+1 → 0x80000000, negative=1, overflow=1, CarryOut=0. SUB 5−5 → 0, zero=1, CarryOut=1. SLT 0xFFFFFFFF,1 → 1. Back-to-back, out_valid high every cycle.
- MUL WIDTH=32: 0x10000×0x10000 → memAddr=0, zero=1, overflow=1, out_valid after 33 edges. 7×6 → 42, overflow=0. storedRt2 = value captured at accept.
- Stall: stall_in=1 for 3 cycles after a valid ADD → memAddr/out_valid held, in_ready=0. MUL with stall_in high at DONE for 2 cycles → result appears 2 cycles late, value correct.
- Flush: flush on MUL cycle 10 → busy=0 next edge, no out_valid for that instruction. Flush with valid ADD in EX/MEM → out_valid=0. Flush+stall together → out_valid=0.
- WIDTH=8 instance: 0xFF+0x01 → 0x00, CarryOut=1, zero=1. MUL 0x10×0x10 → 0x00, overflow=1, latency 9 edges.
